// File: rtl/msg_words_pkg.sv
// -----------------------------------------------------------------------------
// msg_words_pkg
// Shared types and helpers for the multi-word message payload decoder.
//   state_e        : sequencer state encoding (IDLE/FILL/DONE)
//   clog2/idx_width: index-width helpers (idx_width never returns less than 1)
//   TOTAL_BYTES    : payload bytes per message for the default configuration
//   CHECKSUM_ZERO  : running sum that marks a valid checksummed message
// -----------------------------------------------------------------------------
package msg_words_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_WORD_BYTES = 2;
  localparam int DEF_NUM_WORDS  = 4;
  localparam int TOTAL_BYTES    = DEF_WORD_BYTES * DEF_NUM_WORDS;

  localparam logic [7:0] CHECKSUM_ZERO = 8'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Index width for a counter/select over 'value' entries; a single entry
  // still needs a one-bit signal.
  function automatic int idx_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/msg_byte_sequencer.sv
// -----------------------------------------------------------------------------
// msg_byte_sequencer
// Byte/word counters and the message FSM. Tells the datapath where each
// accepted byte goes and when the shadow bank must be committed.
// Optional feature macro: MSG_WORDS_CHECKSUM_EN (adds a trailing checksum byte).
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : start of a new message (wins over write_i)
//   write_i         : a payload byte is presented this cycle
//   cs_ok_i         : (checksum build) running sum incl. this byte is zero
//   wr_en_o         : store the presented byte into shadow[word_sel][byte_sel]
//   word_sel_o      : word index of the presented byte
//   byte_sel_o      : byte index within the word
//   commit_o        : this edge copies the (merged) shadow bank to the output bank
//   complete_o      : registered one-cycle pulse after a commit
//   cs_error_o      : (checksum build) registered one-cycle pulse on bad checksum
//   overflow_o      : sticky, byte arrived after completion
//   state_o         : current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module msg_byte_sequencer
  import msg_words_pkg::*;
#(
  parameter  int WORD_BYTES = DEF_WORD_BYTES,
  parameter  int NUM_WORDS  = DEF_NUM_WORDS,
  localparam int AW         = idx_width(NUM_WORDS),
  localparam int BW         = idx_width(WORD_BYTES)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          write_i,
`ifdef MSG_WORDS_CHECKSUM_EN
  input  logic          cs_ok_i,
  output logic          cs_error_o,
`endif
  output logic          wr_en_o,
  output logic [AW-1:0] word_sel_o,
  output logic [BW-1:0] byte_sel_o,
  output logic          commit_o,
  output logic          complete_o,
  output logic          overflow_o,
  output state_e        state_o
);

  state_e        state_q;
  logic [AW-1:0] wi_q;
  logic [BW-1:0] bi_q;
  logic          overflow_q;
  logic          complete_q;

  logic take;       // a byte is offered and not pre-empted by clear
  logic last_word_byte;
  logic last_byte;  // counters point at the final payload byte
  logic data_en;
  logic commit;

`ifdef MSG_WORDS_CHECKSUM_EN
  logic cs_phase_q; // all payload bytes stored, next byte is the checksum
  logic error_q;
  logic cs_en;
  logic cs_fail;
`endif

  always_comb begin
    take           = write_i && !clear_i;
    last_word_byte = (bi_q == BW'(WORD_BYTES - 1));
    last_byte      = last_word_byte && (wi_q == AW'(NUM_WORDS - 1));
`ifdef MSG_WORDS_CHECKSUM_EN
    data_en = take && (state_q != S_DONE) && !cs_phase_q;
    cs_en   = take && cs_phase_q;
    commit  = cs_en && cs_ok_i;
    cs_fail = cs_en && !cs_ok_i;
`else
    data_en = take && (state_q != S_DONE);
    // IDLE has zero counters, so a one-byte message commits straight from IDLE.
    commit  = data_en && last_byte;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wi_q       <= '0;
      bi_q       <= '0;
      overflow_q <= 1'b0;
      complete_q <= 1'b0;
`ifdef MSG_WORDS_CHECKSUM_EN
      cs_phase_q <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      complete_q <= commit;
`ifdef MSG_WORDS_CHECKSUM_EN
      error_q    <= cs_fail;
`endif
      if (clear_i) begin
        state_q    <= S_IDLE;
        wi_q       <= '0;
        bi_q       <= '0;
        overflow_q <= 1'b0;
`ifdef MSG_WORDS_CHECKSUM_EN
        cs_phase_q <= 1'b0;
`endif
      end else if (data_en) begin
        if (last_word_byte) begin
          bi_q <= '0;
          wi_q <= (wi_q == AW'(NUM_WORDS - 1)) ? '0 : wi_q + 1'b1;
        end else begin
          bi_q <= bi_q + 1'b1;
        end
        if (last_byte) begin
`ifdef MSG_WORDS_CHECKSUM_EN
          cs_phase_q <= 1'b1;
          state_q    <= S_FILL;
`else
          state_q    <= S_DONE;
`endif
        end else begin
          state_q <= S_FILL;
        end
`ifdef MSG_WORDS_CHECKSUM_EN
      end else if (cs_en) begin
        cs_phase_q <= 1'b0;
        state_q    <= S_DONE;
`endif
      end else if (take && (state_q == S_DONE)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign wr_en_o    = data_en;
  assign word_sel_o = wi_q;
  assign byte_sel_o = bi_q;
  assign commit_o   = commit;
  assign complete_o = complete_q;
  assign overflow_o = overflow_q;
  assign state_o    = state_q;
`ifdef MSG_WORDS_CHECKSUM_EN
  assign cs_error_o = error_q;
`endif

endmodule

// File: rtl/message_words.sv
// -----------------------------------------------------------------------------
// message_words
// Assembles NUM_WORDS words of WORD_BYTES bytes each from a byte stream into a
// shadow bank and commits it atomically to the readable output bank once the
// whole message has arrived, so readers never see a half-updated message.
// Optional feature macro: MSG_WORDS_CHECKSUM_EN (trailing mod-256 checksum byte;
// commit only when the sum of all bytes is zero, else pulse ChecksumError).
//
// Ports:
//   Clock           : system clock, rising edge
//   Reset_n         : asynchronous active-low reset
//   ClearAddr       : start of new message (drops a same-cycle byte)
//   WriteByte       : DataByte valid this cycle
//   DataByte        : payload byte, least-significant byte of each word first
//   ReadAddr        : word select for DataWord
//   DataWord        : output-bank word at ReadAddr, 0 when out of range
//   MessageComplete : one-cycle pulse, output bank has just been updated
//   Busy            : message partially received
//   ChecksumError   : (checksum build) one-cycle pulse, message rejected
//   Overflow        : sticky, byte arrived after completion
// -----------------------------------------------------------------------------
module message_words
  import msg_words_pkg::*;
#(
  parameter  int WORD_BYTES = DEF_WORD_BYTES,
  parameter  int NUM_WORDS  = DEF_NUM_WORDS,
  localparam int W          = 8 * WORD_BYTES,
  localparam int AW         = idx_width(NUM_WORDS),
  localparam int BW         = idx_width(WORD_BYTES)
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          ClearAddr,
  input  logic          WriteByte,
  input  logic [7:0]    DataByte,
  input  logic [AW-1:0] ReadAddr,
  output logic [W-1:0]  DataWord,
  output logic          MessageComplete,
  output logic          Busy,
`ifdef MSG_WORDS_CHECKSUM_EN
  output logic          ChecksumError,
`endif
  output logic          Overflow
);

  logic [NUM_WORDS-1:0][W-1:0] shadow_q, shadow_d;
  logic [NUM_WORDS-1:0][W-1:0] bank_q, bank_d;

  logic          wr_en;
  logic [AW-1:0] word_sel;
  logic [BW-1:0] byte_sel;
  logic          commit;
  state_e        seq_state;

`ifdef MSG_WORDS_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic       cs_ok;

  assign sum_d = sum_q + DataByte;
  assign cs_ok = (sum_d == CHECKSUM_ZERO);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)       sum_q <= 8'h00;
    else if (ClearAddr) sum_q <= 8'h00;
    else if (wr_en)     sum_q <= sum_d;
  end
`endif

  msg_byte_sequencer #(
    .WORD_BYTES (WORD_BYTES),
    .NUM_WORDS  (NUM_WORDS)
  ) u_seq (
    .clk_i      (Clock),
    .rst_ni     (Reset_n),
    .clear_i    (ClearAddr),
    .write_i    (WriteByte),
`ifdef MSG_WORDS_CHECKSUM_EN
    .cs_ok_i    (cs_ok),
    .cs_error_o (ChecksumError),
`endif
    .wr_en_o    (wr_en),
    .word_sel_o (word_sel),
    .byte_sel_o (byte_sel),
    .commit_o   (commit),
    .complete_o (MessageComplete),
    .overflow_o (Overflow),
    .state_o    (seq_state)
  );

  // The commit copies shadow_d rather than shadow_q so the final payload byte,
  // written on the same edge, lands in the output bank too.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) shadow_d[word_sel][8*byte_sel +: 8] = DataByte;
    bank_d = bank_q;
    if (commit) bank_d = shadow_d;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_q <= '0;
      bank_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      bank_q   <= bank_d;
    end
  end

  assign DataWord = ({1'b0, ReadAddr} < (AW+1)'(NUM_WORDS)) ? bank_q[ReadAddr] : '0;
  assign Busy     = (seq_state == S_FILL);

endmodule

// File: tb/tb_message_words.sv
`timescale 1ns/100ps
module tb_message_words;

  localparam int WB    = 2;
  localparam int NW    = 4;
  localparam int W     = 8 * WB;
  localparam int TOTAL = WB * NW;

  logic         Clock;
  logic         Reset_n;
  logic         ClearAddr;
  logic         WriteByte;
  logic [7:0]   DataByte;
  logic [1:0]   ReadAddr;
  logic [W-1:0] DataWord;
  logic         MessageComplete;
  logic         Busy;
  logic         Overflow;

  int checks = 0;
  int errors = 0;

  message_words #(.WORD_BYTES(WB), .NUM_WORDS(NW)) dut (
    .Clock           (Clock),
    .Reset_n         (Reset_n),
    .ClearAddr       (ClearAddr),
    .WriteByte       (WriteByte),
    .DataByte        (DataByte),
    .ReadAddr        (ReadAddr),
    .DataWord        (DataWord),
    .MessageComplete (MessageComplete),
    .Busy            (Busy),
    .Overflow        (Overflow)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clock = 1'b0;
    forever #10 Clock = ~Clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // The model keeps the bytes of the message in flight as a list and builds
  // words from it with plain arithmetic when the list reaches TOTAL bytes.
  logic [7:0]   msg_q[$];
  logic [W-1:0] exp_bank[NW];
  bit           m_done, m_ovf, exp_mc, exp_busy;

  task automatic model_reset();
    msg_q.delete();
    for (int a = 0; a < NW; a++) exp_bank[a] = '0;
    m_done = 0; m_ovf = 0; exp_mc = 0; exp_busy = 0;
  endtask

  task automatic model_step(input bit clr, input bit wr, input logic [7:0] b);
    logic [W-1:0] word;
    exp_mc = 0;
    if (clr) begin
      msg_q.delete();
      m_done = 0;
      m_ovf  = 0;
    end else if (wr) begin
      if (m_done) m_ovf = 1;
      else begin
        msg_q.push_back(b);
        if (msg_q.size() == TOTAL) begin
          for (int w = 0; w < NW; w++) begin
            word = '0;
            for (int j = 0; j < WB; j++) word = word | (W'(msg_q[w*WB+j]) << (8*j));
            exp_bank[w] = word;
          end
          m_done = 1;
          exp_mc = 1;
          msg_q.delete();
        end
      end
    end
    exp_busy = (msg_q.size() != 0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " complete"}, 32'(MessageComplete), 32'(exp_mc));
    chk({tag, " busy"}, 32'(Busy), 32'(exp_busy));
    chk({tag, " overflow"}, 32'(Overflow), 32'(m_ovf));
    for (int a = 0; a < NW; a++) begin
      ReadAddr = 2'(a);
      #1;
      chk($sformatf("%s word%0d", tag, a), 32'(DataWord), 32'(exp_bank[a]));
    end
  endtask

  task automatic check_bank_const(input string tag, input logic [W-1:0] w0,
                                  input logic [W-1:0] w1, input logic [W-1:0] w2,
                                  input logic [W-1:0] w3);
    logic [W-1:0] req[NW];
    req[0] = w0; req[1] = w1; req[2] = w2; req[3] = w3;
    for (int a = 0; a < NW; a++) begin
      ReadAddr = 2'(a);
      #1;
      chk($sformatf("%s const word%0d", tag, a), 32'(DataWord), 32'(req[a]));
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1ns after the
  // rising edge that consumed them.
  task automatic step(input bit clr, input bit wr, input logic [7:0] b);
    @(negedge Clock);
    ClearAddr = clr;
    WriteByte = wr;
    DataByte  = b;
    model_step(clr, wr, b);
    @(posedge Clock);
    #1;
    ClearAddr = 1'b0;
    WriteByte = 1'b0;
  endtask

  task automatic send_msg(input string tag, input logic [7:0] first);
    for (int i = 0; i < TOTAL; i++) begin
      step(0, 1, first + 8'(i));
      check_model($sformatf("%s b%0d", tag, i));
    end
  endtask

  typedef struct {
    bit         clr;
    bit         wr;
    logic [7:0] data;
    bit         mc;
    bit         busy;
    bit         ovf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    Reset_n = 1'b0; ClearAddr = 1'b0; WriteByte = 1'b0; DataByte = 8'h00; ReadAddr = 2'd0;
    model_reset();

    // Table: clean message 01..08, then overflow byte, then clear.
    tbl[0] = '{1, 0, 8'h00, 0, 0, 0};
    for (int i = 1; i <= 7; i++) tbl[i] = '{0, 1, 8'(i), 0, 1, 0};
    tbl[8]  = '{0, 1, 8'h08, 1, 0, 0};
    tbl[9]  = '{0, 0, 8'h00, 0, 0, 0};
    tbl[10] = '{0, 1, 8'hAA, 0, 0, 1};
    tbl[11] = '{0, 0, 8'h00, 0, 0, 1};
    tbl[12] = '{1, 0, 8'h00, 0, 0, 0};

    repeat (2) @(negedge Clock);
    check_model("reset");
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].clr, tbl[i].wr, tbl[i].data);
      chk($sformatf("tbl%0d complete", i), 32'(MessageComplete), 32'(tbl[i].mc));
      chk($sformatf("tbl%0d busy", i), 32'(Busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d overflow", i), 32'(Overflow), 32'(tbl[i].ovf));
      check_model($sformatf("tbl%0d", i));
    end
    check_bank_const("msg1", 16'h0201, 16'h0403, 16'h0605, 16'h0807);

    // Partial message discarded by ClearAddr, then a full new message.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h31 + 8'(i));
      check_model($sformatf("partial b%0d", i));
    end
    step(1, 0, 8'h00);
    check_model("partial clear");
    check_bank_const("after partial", 16'h0201, 16'h0403, 16'h0605, 16'h0807);
    send_msg("msg2", 8'h11);
    check_bank_const("msg2", 16'h1211, 16'h1413, 16'h1615, 16'h1817);

    // Overflow after completion, bank unchanged, cleared by ClearAddr.
    step(0, 1, 8'hAA);
    check_model("ovf");
    check_bank_const("ovf", 16'h1211, 16'h1413, 16'h1615, 16'h1817);
    step(1, 0, 8'h00);
    check_model("ovf clear");

    // ClearAddr and WriteByte together: byte dropped.
    step(1, 1, 8'h55);
    check_model("clr+wr");
    send_msg("msg3", 8'h21);
    check_bank_const("msg3", 16'h2221, 16'h2423, 16'h2625, 16'h2827);

    // Asynchronous reset mid-word.
    step(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h41 + 8'(i));
      check_model($sformatf("pre-reset b%0d", i));
    end
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async reset");
    @(negedge Clock);
    Reset_n = 1'b1;
    step(0, 0, 8'h00);
    check_model("post reset idle");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/message_words.md
Name: message_words

Overview:
- Parametrised successor to the single-word message payload decoder.
- Accepts payload bytes from the MsgRouter byte interface and assembles NUM_WORDS words, each WORD_BYTES wide.
- Stages bytes in a shadow bank. Commits the shadow bank atomically to a readable output bank when the message completes.
- Signals completion and overflow, so downstream logic never sees a half-updated message.

Parameters:
- WORD_BYTES, 2: bytes per word; W = 8*WORD_BYTES; must be >= 1.
- NUM_WORDS, 4: words per message; must be >= 1.
- AW, derived: max(1, clog2(NUM_WORDS)); localparam, not overridable.

Ports:
- Clock in 1: single system clock, rising edge.
- Reset_n in 1: asynchronous, active-low reset.
- ClearAddr in 1: start of new message; resets byte/word counters.
- WriteByte in 1: DataByte valid this cycle.
- DataByte in 8: payload byte.
- ReadAddr in AW: word select for DataWord.
- DataWord out W: output-bank word at ReadAddr (combinational mux).
- MessageComplete out 1: one-cycle pulse; output bank has just been updated.
- Busy out 1: message partially received.
- Overflow out 1: sticky; a byte arrived after completion.

Behaviour:
- Reset (Reset_n=0, async): state IDLE, counters 0, shadow and output banks 0, MessageComplete=0, Overflow=0, Busy=0.
- Counters:
  - Byte index BI runs 0..WORD_BYTES-1; word index WI runs 0..NUM_WORDS-1.
  - BI wraps to 0 and WI increments on the last byte of a word.
- Byte placement: byte BI of word WI goes to shadow[WI][8*BI+7:8*BI], least-significant byte first.
- FSM states:
  - IDLE: WriteByte accepts byte 0 and moves to FILL. If TOTAL = WORD_BYTES*NUM_WORDS = 1, it goes directly to DONE.
  - FILL: each WriteByte stores one byte. On the final byte (WI=NUM_WORDS-1, BI=WORD_BYTES-1), the same edge copies shadow to the output bank, with the final byte merged, and the state moves to DONE.
  - DONE: WriteByte is ignored (no storage) and sets Overflow. The state stays DONE until ClearAddr.
- MessageComplete:
  - Registered; high for exactly one cycle, the cycle after the edge that accepted the final byte.
  - DataWord reflects the new bank in that same cycle.
- Busy = (state==FILL).
- ClearAddr:
  - Takes priority over WriteByte in the same cycle; the byte is dropped.
  - Sets state IDLE, BI=WI=0, Overflow=0.
  - Leaves the shadow bank unchanged and the output bank retained.
- ClearAddr mid-message: partial data is discarded and never committed; the output bank holds the previous complete message.
- WriteByte with no intervening ClearAddr after completion is an overflow, not a new message.
- ReadAddr >= NUM_WORDS: DataWord = 0.
- Reset mid-message: all state cleared immediately; no completion pulse.

Optional Feature:
- Macro: MSG_WORDS_CHECKSUM_EN.
- Enabled:
  - The message is TOTAL+1 bytes; the extra trailing byte is a checksum.
  - An 8-bit accumulator sums all bytes mod 256 and is cleared by ClearAddr/reset.
  - On the checksum byte: if the sum including the checksum == 0x00, commit and pulse MessageComplete. Otherwise do not commit, pulse ChecksumError one cycle, and go to DONE.
  - Adds output port ChecksumError (1 bit).
- Disabled: no accumulator, no ChecksumError port, and behaviour exactly as above.

Decomposition:
- Package msg_words_pkg:
  - State encoding: IDLE=2'd0, FILL=2'd1, DONE=2'd2.
  - clog2 function.
  - Localparams TOTAL_BYTES and CHECKSUM_ZERO=8'h00.
- Sub-module msg_byte_sequencer:
  - Contains BI/WI counters and the FSM.
  - Outputs the write strobe, word/byte select, commit and overflow.
- The top level holds the shadow/output banks, the read mux and the optional checksum accumulator.

Test Plan (defaults WORD_BYTES=2, NUM_WORDS=4):
- Reset, then ClearAddr and bytes 01..08 -> MessageComplete one cycle after byte 08; word0=0x0201, word1=0x0403, word2=0x0605, word3=0x0807; Busy low.
- Five bytes, then ClearAddr, then full message 11..18 -> output bank shows 0x0201.. until commit, then 0x1211,0x1413,0x1615,0x1817; no pulse for the partial message.
- Complete message, then WriteByte 0xAA -> Overflow=1 and bank unchanged; next ClearAddr -> Overflow=0.
- ClearAddr and WriteByte asserted the same cycle -> byte dropped, BI=WI=0; the next 8 bytes form a clean message.
- Reset_n pulled low mid-word (after byte 3) asynchronously -> all outputs 0 immediately; no MessageComplete.
- With MSG_WORDS_CHECKSUM_EN:
  - Bytes 01..08 plus 0xDC (sum 0x24) -> MessageComplete.
  - Checksum 0xDD instead -> ChecksumError pulse, bank unchanged.
